// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types and widths for the tensor-core scoreboard datapath
package datapath_pkg;

    localparam int TAG_W = 2;
    localparam int REG_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_EXEC,
        ST_DRAIN
    } gemm_iss_state_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rs3;
        logic             spec;
    } gemm_op_t;

endpackage

// File: rtl/tag_wakeup.sv
// rtl/tag_wakeup.sv - clears producer tags matching a writeback broadcast
module tag_wakeup
    import datapath_pkg::*;
(
    input  logic [TAG_W-1:0] i_t1,
    input  logic [TAG_W-1:0] i_t2,
    input  logic [TAG_W-1:0] i_t3,
    input  logic             i_wb_valid,
    input  logic [TAG_W-1:0] i_wb_tag,
    output logic [TAG_W-1:0] o_t1,
    output logic [TAG_W-1:0] o_t2,
    output logic [TAG_W-1:0] o_t3,
    output logic             o_all_ready
);

    logic w_bcast;

    // Tag 0 means "already ready", so a broadcast of 0 must never match.
    assign w_bcast     = i_wb_valid && (i_wb_tag != '0);
    assign o_t1        = (w_bcast && (i_t1 == i_wb_tag)) ? '0 : i_t1;
    assign o_t2        = (w_bcast && (i_t2 == i_wb_tag)) ? '0 : i_t2;
    assign o_t3        = (w_bcast && (i_t3 == i_wb_tag)) ? '0 : i_t3;
    assign o_all_ready = ~|{o_t1, o_t2, o_t3};

endmodule

// File: rtl/gemm_issue_ctrl.sv
// rtl/gemm_issue_ctrl.sv - issue-side reader of the GEMM functional-unit status entry
module gemm_issue_ctrl
    import datapath_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             fust_busy,
    input  logic [REG_W-1:0] fust_rd,
    input  logic [REG_W-1:0] fust_rs1,
    input  logic [REG_W-1:0] fust_rs2,
    input  logic [REG_W-1:0] fust_rs3,
    input  logic             fust_spec,
    input  logic [TAG_W-1:0] fust_t1,
    input  logic [TAG_W-1:0] fust_t2,
    input  logic [TAG_W-1:0] fust_t3,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    output logic [TAG_W-1:0] t1_nxt,
    output logic [TAG_W-1:0] t2_nxt,
    output logic [TAG_W-1:0] t3_nxt,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [REG_W-1:0] issue_rd,
    output logic [REG_W-1:0] issue_rs1,
    output logic [REG_W-1:0] issue_rs2,
    output logic [REG_W-1:0] issue_rs3,
    input  logic             gemm_done,
    output logic             done_valid,
    output logic [REG_W-1:0] done_rd,
    output logic             busy_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    gemm_iss_state_t  r_state, w_state_nxt;
    gemm_op_t         r_op;
    logic [TAG_W-1:0] r_t1, r_t2, r_t3;
    logic [TAG_W-1:0] w_t1, w_t2, w_t3;
    logic             w_all_ready;
    logic             w_capture;
    logic             w_kill;
    logic             w_tracking;
    logic [CNT_W-1:0] r_stall_cnt;

    tag_wakeup u_tag_wakeup (
        .i_t1        (r_t1),
        .i_t2        (r_t2),
        .i_t3        (r_t3),
        .i_wb_valid  (wb_valid),
        .i_wb_tag    (wb_tag),
        .o_t1        (w_t1),
        .o_t2        (w_t2),
        .o_t3        (w_t3),
        .o_all_ready (w_all_ready)
    );

    assign w_capture  = (r_state == ST_IDLE) && fust_busy && !(flush && fust_spec);
    assign w_kill     = flush && r_op.spec;
    assign w_tracking = (r_state == ST_WAIT) || (r_state == ST_ISSUE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_capture) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_kill)           w_state_nxt = ST_IDLE;
                else if (w_all_ready) w_state_nxt = ST_ISSUE;
            end
            // A handshake that lands in the flush cycle is already in flight; drain it.
            ST_ISSUE: begin
                if (issue_ready)  w_state_nxt = w_kill ? ST_DRAIN : ST_EXEC;
                else if (w_kill)  w_state_nxt = ST_IDLE;
            end
            ST_EXEC: begin
                if (gemm_done)    w_state_nxt = ST_IDLE;
                else if (w_kill)  w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (gemm_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_t3        <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_op <= '{rd: fust_rd, rs1: fust_rs1, rs2: fust_rs2, rs3: fust_rs3, spec: fust_spec};
                r_t1 <= fust_t1;
                r_t2 <= fust_t2;
                r_t3 <= fust_t3;
            end else if (w_tracking) begin
                r_t1 <= w_t1;
                r_t2 <= w_t2;
                r_t3 <= w_t3;
            end
            if ((r_state == ST_WAIT) && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign t1_nxt      = w_tracking ? w_t1 : '0;
    assign t2_nxt      = w_tracking ? w_t2 : '0;
    assign t3_nxt      = w_tracking ? w_t3 : '0;
    assign issue_valid = (r_state == ST_ISSUE);
    assign issue_rd    = issue_valid ? r_op.rd  : '0;
    assign issue_rs1   = issue_valid ? r_op.rs1 : '0;
    assign issue_rs2   = issue_valid ? r_op.rs2 : '0;
    assign issue_rs3   = issue_valid ? r_op.rs3 : '0;
    assign done_valid  = (r_state == ST_EXEC) && gemm_done;
    assign done_rd     = done_valid ? r_op.rd : '0;
    assign busy_clr    = done_valid;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_gemm_issue_ctrl.sv
// tb/tb_gemm_issue_ctrl.sv - directed self-checking bench for gemm_issue_ctrl
module tb_gemm_issue_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        fust_busy, fust_spec, wb_valid, flush, issue_ready, gemm_done;
    logic [3:0]  fust_rd, fust_rs1, fust_rs2, fust_rs3;
    logic [1:0]  fust_t1, fust_t2, fust_t3, wb_tag;
    logic [1:0]  t1_nxt, t2_nxt, t3_nxt;
    logic        issue_valid, done_valid, busy_clr;
    logic [3:0]  issue_rd, issue_rs1, issue_rs2, issue_rs3, done_rd;
    logic [15:0] stall_cnt;
    logic [15:0] exp_stall;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    gemm_issue_ctrl dut (
        .CLK(CLK), .nRST(nRST), .fust_busy(fust_busy),
        .fust_rd(fust_rd), .fust_rs1(fust_rs1), .fust_rs2(fust_rs2), .fust_rs3(fust_rs3),
        .fust_spec(fust_spec), .fust_t1(fust_t1), .fust_t2(fust_t2), .fust_t3(fust_t3),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush),
        .t1_nxt(t1_nxt), .t2_nxt(t2_nxt), .t3_nxt(t3_nxt),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
        .gemm_done(gemm_done), .done_valid(done_valid), .done_rd(done_rd),
        .busy_clr(busy_clr), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic present_op(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [3:0] rs3, input logic spec,
                              input logic [1:0] t1, input logic [1:0] t2, input logic [1:0] t3);
        fust_busy = 1'b1; fust_rd = rd; fust_rs1 = rs1; fust_rs2 = rs2; fust_rs3 = rs3;
        fust_spec = spec; fust_t1 = t1; fust_t2 = t2; fust_t3 = t3;
    endtask

    task automatic test_reset();
        nRST = 1'b0; fust_busy = 0; fust_spec = 0; wb_valid = 0; flush = 0; issue_ready = 0;
        gemm_done = 0; fust_rd = 0; fust_rs1 = 0; fust_rs2 = 0; fust_rs3 = 0;
        fust_t1 = 0; fust_t2 = 0; fust_t3 = 0; wb_tag = 0; exp_stall = 0;
        tick(); tick();
        checks++;
        if ({issue_valid, done_valid, busy_clr, issue_rd, done_rd, t1_nxt, t2_nxt, t3_nxt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: iv=%b dv=%b bc=%b ird=%h drd=%h t=%h%h%h stall=%0d, need all 0",
                     issue_valid, done_valid, busy_clr, issue_rd, done_rd, t1_nxt, t2_nxt, t3_nxt, stall_cnt);
        end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_min_latency();
        present_op(4'd5, 4'd1, 4'd2, 4'd3, 1'b0, 2'd0, 2'd0, 2'd0);   // cycle 0
        issue_ready = 1'b1;
        tick(); fust_busy = 0;                                          // cycle 1: WAIT
        checks++;
        if (issue_valid !== 1'b0) begin errors++; $display("FAIL minlat_c1_valid: got %b need 0", issue_valid); end
        tick(); exp_stall = exp_stall + 1;                              // cycle 2: ISSUE
        checks++;
        if (issue_valid !== 1'b1 || issue_rd !== 4'd5) begin
            errors++; $display("FAIL minlat_issue: valid=%b rd=%0d need 1/5", issue_valid, issue_rd);
        end
        tick(); issue_ready = 0;                                        // cycle 3: EXEC
        checks++;
        if (issue_valid !== 1'b0) begin errors++; $display("FAIL minlat_exec_valid: got %b need 0", issue_valid); end
        tick(); tick(); tick();                                         // cycle 6
        gemm_done = 1'b1; #1;
        checks++;
        if (done_valid !== 1'b1 || done_rd !== 4'd5 || busy_clr !== 1'b1) begin
            errors++; $display("FAIL minlat_done: dv=%b rd=%0d bc=%b need 1/5/1", done_valid, done_rd, busy_clr);
        end
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL minlat_stall: got %0d need %0d", stall_cnt, exp_stall); end
        tick(); gemm_done = 0; #1;                                      // cycle 7: IDLE
        checks++;
        if (done_valid !== 1'b0 || busy_clr !== 1'b0) begin
            errors++; $display("FAIL minlat_idle_pulse: dv=%b bc=%b need 0/0", done_valid, busy_clr);
        end
    endtask

    task automatic test_wakeup();
        present_op(4'd6, 4'd7, 4'd8, 4'd9, 1'b0, 2'd1, 2'd2, 2'd1);   // cycle 0
        tick(); fust_busy = 0;                                          // cycle 1: WAIT
        checks++;
        if ({t1_nxt, t2_nxt, t3_nxt} !== {2'd1, 2'd2, 2'd1}) begin
            errors++; $display("FAIL wake_latched: got %0d/%0d/%0d need 1/2/1", t1_nxt, t2_nxt, t3_nxt);
        end
        tick(); wb_valid = 1; wb_tag = 2'd0; #1;                        // cycle 2: tag-0 broadcast
        checks++;
        if ({t1_nxt, t2_nxt, t3_nxt} !== {2'd1, 2'd2, 2'd1}) begin
            errors++; $display("FAIL wake_tag0: got %0d/%0d/%0d need 1/2/1", t1_nxt, t2_nxt, t3_nxt);
        end
        tick(); wb_tag = 2'd1; #1;                                      // cycle 3
        checks++;
        if ({t1_nxt, t2_nxt, t3_nxt} !== {2'd0, 2'd2, 2'd0}) begin
            errors++; $display("FAIL wake_c3: got %0d/%0d/%0d need 0/2/0", t1_nxt, t2_nxt, t3_nxt);
        end
        tick(); wb_valid = 0; wb_tag = 0; tick();                       // cycle 5
        checks++;
        if (issue_valid !== 1'b0 || t2_nxt !== 2'd2 || t1_nxt !== 2'd0) begin
            errors++; $display("FAIL wake_c5: iv=%b t1=%0d t2=%0d need 0/0/2", issue_valid, t1_nxt, t2_nxt);
        end
        tick(); wb_valid = 1; wb_tag = 2'd2; #1;                        // cycle 6
        checks++;
        if (t2_nxt !== 2'd0) begin errors++; $display("FAIL wake_c6: t2=%0d need 0", t2_nxt); end
        tick(); wb_valid = 0; wb_tag = 0; exp_stall = exp_stall + 6;    // cycle 7: WAIT spanned cycles 1..6
        checks++;
        if (issue_valid !== 1'b1 || issue_rd !== 4'd6 || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL wake_issue: iv=%b rd=%0d stall=%0d need 1/6/%0d", issue_valid, issue_rd, stall_cnt, exp_stall);
        end
        issue_ready = 1; tick(); issue_ready = 0;                       // cycle 8: EXEC
        gemm_done = 1; tick(); gemm_done = 0;
    endtask

    task automatic test_backpressure();
        present_op(4'd9, 4'd1, 4'd2, 4'd3, 1'b0, 2'd0, 2'd0, 2'd0);
        tick(); fust_busy = 0; tick(); exp_stall = exp_stall + 1;       // cycle 2: ISSUE, ready low
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (issue_valid !== 1'b1 || {issue_rd, issue_rs1, issue_rs2, issue_rs3} !== 16'h9123) begin
                errors++; $display("FAIL bp_hold%0d: iv=%b fields=%h need 1/9123", i, issue_valid,
                                   {issue_rd, issue_rs1, issue_rs2, issue_rs3});
            end
            tick();
        end
        issue_ready = 1; #1;                                            // cycle 5
        checks++;
        if (issue_valid !== 1'b1 || issue_rd !== 4'd9) begin
            errors++; $display("FAIL bp_accept: iv=%b rd=%0d need 1/9", issue_valid, issue_rd);
        end
        tick(); issue_ready = 0;                                        // cycle 6: EXEC
        gemm_done = 1; #1;
        checks++;
        if (issue_valid !== 1'b0 || done_valid !== 1'b1 || done_rd !== 4'd9) begin
            errors++; $display("FAIL bp_exec: iv=%b dv=%b rd=%0d need 0/1/9", issue_valid, done_valid, done_rd);
        end
        tick(); gemm_done = 0;
    endtask

    task automatic test_flush_wait();
        present_op(4'd2, 4'd0, 4'd0, 4'd0, 1'b1, 2'd3, 2'd0, 2'd0);
        flush = 1; tick(); fust_busy = 0; flush = 0;                    // flushed at capture: stays IDLE
        checks++;
        if (t1_nxt !== 2'd0) begin errors++; $display("FAIL flush_idle: t1=%0d need 0", t1_nxt); end
        present_op(4'd2, 4'd0, 4'd0, 4'd0, 1'b1, 2'd3, 2'd0, 2'd0);
        tick(); fust_busy = 0;                                          // cycle 1: WAIT
        checks++;
        if (t1_nxt !== 2'd3) begin errors++; $display("FAIL flush_wait_pre: t1=%0d need 3", t1_nxt); end
        tick(); flush = 1; #1;                                          // cycle 2
        checks++;
        if (busy_clr !== 1'b0) begin errors++; $display("FAIL flush_wait_bc: got %b need 0", busy_clr); end
        tick(); flush = 0; exp_stall = exp_stall + 2;                   // cycle 3: IDLE
        wb_valid = 1; wb_tag = 2'd3; #1;
        checks++;
        if (t1_nxt !== 2'd0 || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL flush_wait_idle: t1=%0d stall=%0d need 0/%0d", t1_nxt, stall_cnt, exp_stall);
        end
        tick(); wb_valid = 0; wb_tag = 0;
        checks++;
        if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_noissue: iv=%b need 0", issue_valid); end
        present_op(4'd11, 4'd0, 4'd0, 4'd0, 1'b0, 2'd1, 2'd0, 2'd0);   // non-speculative op
        tick(); fust_busy = 0; tick(); flush = 1; tick(); flush = 0;    // cycle 3 after flush at 2
        checks++;
        if (t1_nxt !== 2'd1) begin errors++; $display("FAIL nonspec_wait: t1=%0d need 1", t1_nxt); end
        wb_valid = 1; wb_tag = 2'd1; tick(); wb_valid = 0; wb_tag = 0;  // cycle 4: ISSUE
        exp_stall = exp_stall + 3;
        flush = 1; tick(); flush = 0;                                   // flush in ISSUE ignored
        checks++;
        if (issue_valid !== 1'b1 || issue_rd !== 4'd11 || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL nonspec_issue: iv=%b rd=%0d stall=%0d need 1/11/%0d", issue_valid, issue_rd, stall_cnt, exp_stall);
        end
        issue_ready = 1; tick(); issue_ready = 0; gemm_done = 1; #1;
        checks++;
        if (done_valid !== 1'b1 || done_rd !== 4'd11) begin
            errors++; $display("FAIL nonspec_done: dv=%b rd=%0d need 1/11", done_valid, done_rd);
        end
        tick(); gemm_done = 0;
    endtask

    task automatic test_flush_exec();
        present_op(4'd7, 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 2'd0, 2'd0);
        tick(); fust_busy = 0; tick(); exp_stall = exp_stall + 1;       // cycle 2: ISSUE
        issue_ready = 1; tick(); issue_ready = 0;                       // cycle 3: EXEC
        flush = 1; tick(); flush = 0;                                   // cycle 4: DRAIN
        gemm_done = 1; #1;
        checks++;
        if (done_valid !== 1'b0 || busy_clr !== 1'b0) begin
            errors++; $display("FAIL drain_done: dv=%b bc=%b need 0/0", done_valid, busy_clr);
        end
        tick(); gemm_done = 0;                                          // cycle k+1: capture new op
        present_op(4'd3, 4'd4, 4'd5, 4'd6, 1'b0, 2'd0, 2'd0, 2'd0);
        tick(); fust_busy = 0; tick(); exp_stall = exp_stall + 1;
        checks++;
        if (issue_valid !== 1'b1 || issue_rd !== 4'd3) begin
            errors++; $display("FAIL drain_next_op: iv=%b rd=%0d need 1/3", issue_valid, issue_rd);
        end
        issue_ready = 1; tick(); issue_ready = 0; gemm_done = 1; #1;
        checks++;
        if (done_valid !== 1'b1 || done_rd !== 4'd3 || busy_clr !== 1'b1) begin
            errors++; $display("FAIL drain_next_done: dv=%b rd=%0d bc=%b need 1/3/1", done_valid, done_rd, busy_clr);
        end
        tick(); gemm_done = 0;
        present_op(4'd8, 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 2'd0, 2'd0);     // flush racing the handshake
        tick(); fust_busy = 0; tick(); exp_stall = exp_stall + 1;
        issue_ready = 1; flush = 1; tick(); issue_ready = 0; flush = 0;
        gemm_done = 1; #1;
        checks++;
        if (issue_valid !== 1'b0 || done_valid !== 1'b0 || busy_clr !== 1'b0 || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL issue_flush_drain: iv=%b dv=%b bc=%b stall=%0d need 0/0/0/%0d",
                               issue_valid, done_valid, busy_clr, stall_cnt, exp_stall);
        end
        tick(); gemm_done = 0;
    endtask

    task automatic test_reset_in_exec();
        present_op(4'd4, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
        tick(); fust_busy = 0; tick(); issue_ready = 1; tick(); issue_ready = 0;   // EXEC
        gemm_done = 1; nRST = 0; #1;
        exp_stall = 0;
        checks++;
        if ({issue_valid, done_valid, busy_clr, done_rd, stall_cnt} !== '0) begin
            errors++; $display("FAIL rst_exec: iv=%b dv=%b bc=%b rd=%0d stall=%0d need all 0",
                               issue_valid, done_valid, busy_clr, done_rd, stall_cnt);
        end
        gemm_done = 0; tick(); nRST = 1; tick();
        gemm_done = 1; #1;
        checks++;
        if (done_valid !== 1'b0 || busy_clr !== 1'b0) begin
            errors++; $display("FAIL rst_late_done: dv=%b bc=%b need 0/0", done_valid, busy_clr);
        end
        tick(); gemm_done = 0;
    endtask

    initial begin
        test_reset();
        test_min_latency();
        test_wakeup();
        test_backpressure();
        test_flush_wait();
        test_flush_exec();
        test_reset_in_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
